// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: default operand
// width, FSM state encoding and the bit-counter sizing helper.
package serial_add_pkg;

   // Default operand/result width; legal range is 1..32.
   localparam int DEFAULT_WIDTH = 8;

   // Controller states, fixed 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The bit counter must hold WIDTH-1. One bit wider than clog2 keeps
   // WIDTH=1 (clog2 = 0) at a legal 1-bit counter.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// The team's 1-bit full-adder cell, consumed one bit pair per clock by the
// serial adder controller. Purely combinational.
module full_adder_cell (
   input  logic A1,
   input  logic B1,
   input  logic Cin,
   output logic Cout,
   output logic Sout
);

   logic w_prop;

   assign w_prop = A1 ^ B1;
   assign Sout   = w_prop ^ Cin;
   assign Cout   = (A1 & B1) | (Cin & w_prop);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Latches two WIDTH-bit operands and a carry-in
// on a start request, feeds the full-adder cell one bit pair per clock (LSB
// first), recirculates the cell's carry-out, and assembles the sum bits into
// a parallel result. busy is high during ADD; done pulses for one cycle when
// sum/cout have just been updated.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_s_sh;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_cell_cout;
   logic             w_cell_sout;
   logic             w_last;
   logic [WIDTH-1:0] w_sum_next;

   // Single instance of the full-adder cell; its inputs are the low bits of
   // the operand shift registers and the recirculated carry.
   full_adder_cell u_fa (
      .A1   (r_a_sh[0]),
      .B1   (r_b_sh[0]),
      .Cin  (r_carry),
      .Cout (w_cell_cout),
      .Sout (w_cell_sout)
   );

   // Final bit of the serial operation is being processed this cycle.
   assign w_last = (r_cnt == LAST_CNT);

   // Sum shift register input: new sum bit enters at the MSB so that after
   // WIDTH shifts the LSB-first stream lines up as a parallel word.
   // A 1-bit result has no older bits to keep, so it is just the cell output.
   if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_cell_sout;
   end else begin : g_sum_wn
      assign w_sum_next = {w_cell_sout, r_s_sh[WIDTH-1:1]};
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of process ordering.
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake output decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave it unassigned and infer a latch.
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_ADD;
            end
         end
         ST_ADD: begin
            busy = 1'b1;
            if (w_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            done         = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Operand capture, serial shifting, carry recirculation and result
   // registration. sum/cout only change on the final ADD edge (or reset),
   // so they hold the previous result across a new start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
               end
            end
            ST_ADD: begin
               r_s_sh  <= w_sum_next;
               r_carry <= w_cell_cout;
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  sum  <= w_sum_next;
                  cout <= w_cell_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit instance for directed
// vectors (ripple, mid-operation start, mid-operation reset) and a 4-bit
// instance swept over every operand/carry combination with start held high.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;

   logic       start4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;

   logic [8:0] q8[$];
   logic [4:0] q4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor for the 8-bit instance: every done pulse must match the oldest
   // outstanding expectation, and busy must be low while done is high.
   initial begin
      forever begin
         @(negedge clk);
         if (done8 === 1'b1) begin
            check("busy8_during_done", busy8, 1'b0);
            if (q8.size() == 0) begin
               check("done8_unexpected", 1'b1, 1'b0);
            end else begin
               check("result8", {cout8, sum8}, q8.pop_front());
            end
         end
      end
   end

   // Monitor for the 4-bit instance.
   initial begin
      forever begin
         @(negedge clk);
         if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
               check("done4_unexpected", 1'b1, 1'b0);
            end else begin
               check("result4", {cout4, sum4}, q4.pop_front());
            end
         end
      end
   end

   // Issue one 8-bit addition with a one-cycle start pulse, then count the
   // busy cycles until done. Returns at the negedge inside the IDLE cycle
   // that follows DONE.
   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [8:0] exp);
      int n;
      @(negedge clk);
      a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
      q8.push_back(exp);
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (busy8 === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("busy8_cycles", n, 8);
      check("done8_after_busy", done8, 1'b1);
      @(negedge clk);
      check("done8_single_pulse", done8, 1'b0);
   endtask

   // Global time bound so a stuck DUT can never hang the run.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         n;
      int         last_done;
      logic [3:0] ea, eb;
      logic       ec;

      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy8", busy8, 1'b0);
      check("reset_done8", done8, 1'b0);
      check("reset_sum8", {cout8, sum8}, 9'h000);
      check("reset_busy4", busy4, 1'b0);
      check("reset_sum4", {cout4, sum4}, 5'h00);
      rst = 1'b0;

      // Directed 8-bit vectors: a, b, cin -> {cout, sum}.
      run8(8'h5A, 8'h3C, 1'b0, 9'h096);
      run8(8'hFF, 8'h01, 1'b0, 9'h100);
      run8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
      run8(8'h00, 8'h00, 1'b0, 9'h000);
      // Result holds across idle cycles.
      repeat (3) @(negedge clk);
      check("hold_sum8", {cout8, sum8}, 9'h000);

      // Second start and operand changes during ADD are ignored.
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      q8.push_back(9'h046);
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
      repeat (2) @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("done8_seen_midstart", done8, 1'b1);
      repeat (12) @(negedge clk);
      check("midstart_no_extra_busy", busy8, 1'b0);

      // Reset on the 4th ADD cycle abandons the operation with no done.
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("busy8_before_reset", busy8, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy8", busy8, 1'b0);
      check("abort_done8", done8, 1'b0);
      check("abort_sum8", {cout8, sum8}, 9'h000);
      repeat (12) @(negedge clk);
      check("abort_stays_idle", busy8, 1'b0);
      run8(8'hAA, 8'h55, 1'b0, 9'h0FF);

      // Exhaustive 4-bit sweep with start held high; done must recur every
      // WIDTH+2 = 6 cycles.
      @(negedge clk);
      a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; start4 = 1'b1;
      q4.push_back(5'h00);
      last_done = 0;
      for (int idx = 0; idx < 512; idx++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (done4 !== 1'b1 && n < 20);
         check("done4_seen", done4, 1'b1);
         if (idx > 0) begin
            check("done4_spacing", cyc - last_done, 6);
         end
         last_done = cyc;
         if (idx < 511) begin
            {ea, eb, ec} = 9'(idx + 1);
            a4 = ea; b4 = eb; cin4 = ec;
            q4.push_back(5'(ea) + 5'(eb) + 5'(ec));
         end else begin
            start4 = 1'b0;
         end
      end

      repeat (10) @(negedge clk);
      check("q8_drained", q8.size(), 0);
      check("q4_drained", q4.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
